// File: rtl/mips_pkg.sv
// Shared constants, fetch-state encoding and the IF/ID payload for the MIPS front end.
package mips_pkg;

  localparam int unsigned PC_W       = 32;
  localparam int unsigned INSTR_W    = 32;
  localparam int unsigned IMEM_AW    = 9;
  localparam int unsigned IMEM_DEPTH = 502;

  localparam logic [PC_W-1:0]    RESET_PC  = 32'h0000_3000;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    RUN  = 1'b0,
    HALT = 1'b1
  } fetch_state_e;

  typedef struct packed {
    logic [INSTR_W-1:0] instr;
    logic [PC_W-1:0]    pc4;
    logic               valid;
  } if_id_t;

  // Misaligned PC or word index beyond the populated ROM (no wrap of indices 502..511).
  function automatic logic pc_faults(input logic [PC_W-1:0] pc_in);
    return (pc_in[1:0] != 2'b00) || (pc_in[IMEM_AW+1:2] >= IMEM_AW'(IMEM_DEPTH));
  endfunction

endpackage

// File: rtl/fetch_pc_gen.sv
// PC register with next-PC mux (redirect / advance / hold) and the fetch fault compare.
module fetch_pc_gen
  import mips_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            advance,
  input  logic            load,
  input  logic [PC_W-1:0] target,
  output logic [PC_W-1:0] pc,
  output logic [PC_W-1:0] pc4_c,
  output logic            fault_c
);

  logic [PC_W-1:0] pc_next;

  // Load has priority; otherwise the PC holds unless told to advance.
  always_comb begin
    pc4_c   = pc + PC_W'(4);
    fault_c = pc_faults(pc);
    pc_next = pc;
    if (load) begin
      pc_next = target;
    end else if (advance) begin
      pc_next = pc4_c;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pc <= RESET_PC;
    end else begin
      pc <= pc_next;
    end
  end

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: PC generation, RUN/HALT control, sticky fault and the IF/ID register.
module if_fetch_stage
  import mips_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic               redirect,
  input  logic [PC_W-1:0]    redirect_pc,
  output logic [IMEM_AW-1:0] imem_addr,
  input  logic [INSTR_W-1:0] imem_rd,
  output logic [PC_W-1:0]    pc,
  output logic [INSTR_W-1:0] if_id_instr,
  output logic [PC_W-1:0]    if_id_pc4,
  output logic               if_id_valid,
  output logic               fetch_fault
);

  fetch_state_e    state, state_next;
  if_id_t          if_id;
  logic            advance, load, bubble, capture, fault_set;
  logic [PC_W-1:0] pc4;
  logic            pc_fault;

  fetch_pc_gen u_pc_gen (
    .clk     (clk),
    .rst     (rst),
    .advance (advance),
    .load    (load),
    .target  (redirect_pc),
    .pc      (pc),
    .pc4_c   (pc4),
    .fault_c (pc_fault)
  );

  assign imem_addr = pc[IMEM_AW+1:2];

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= RUN;
    end else begin
      state <= state_next;
    end
  end

  // Edge priority in RUN: redirect, then stall, then fault check, then normal fetch.
  always_comb begin
    state_next = state;
    advance    = 1'b0;
    load       = 1'b0;
    bubble     = 1'b0;
    capture    = 1'b0;
    fault_set  = 1'b0;
    case (state)
      RUN: begin
        if (redirect) begin
          load   = 1'b1;
          bubble = 1'b1;
        end else if (stall) begin
          bubble = 1'b0;
        end else if (pc_fault) begin
          bubble     = 1'b1;
          fault_set  = 1'b1;
          state_next = HALT;
        end else begin
          advance = 1'b1;
          capture = 1'b1;
        end
      end
      HALT: begin
        bubble = 1'b1;
      end
      default: begin
        state_next = RUN;
      end
    endcase
  end

  // A bubble keeps the last pc4 and only clears instr/valid.
  always_ff @(posedge clk) begin
    if (rst) begin
      if_id.instr <= NOP_INSTR;
      if_id.pc4   <= '0;
      if_id.valid <= 1'b0;
      fetch_fault <= 1'b0;
    end else begin
      if (bubble) begin
        if_id.instr <= NOP_INSTR;
        if_id.valid <= 1'b0;
      end else if (capture) begin
        if_id.instr <= imem_rd;
        if_id.pc4   <= pc4;
        if_id.valid <= 1'b1;
      end
      if (fault_set) begin
        fetch_fault <= 1'b1;
      end
    end
  end

  assign if_id_instr = if_id.instr;
  assign if_id_pc4   = if_id.pc4;
  assign if_id_valid = if_id.valid;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Directed bench for if_fetch_stage with a behavioural ROM and hand-computed expectations.
module tb_if_fetch_stage;

  logic        clk;
  logic        rst;
  logic        stall;
  logic        redirect;
  logic [31:0] redirect_pc;
  logic [8:0]  imem_addr;
  logic [31:0] imem_rd;
  logic [31:0] pc;
  logic [31:0] if_id_instr;
  logic [31:0] if_id_pc4;
  logic        if_id_valid;
  logic        fetch_fault;

  logic [31:0] rom [0:511];
  int n_cmp = 0;
  int n_err = 0;

  if_fetch_stage dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .redirect    (redirect),
    .redirect_pc (redirect_pc),
    .imem_addr   (imem_addr),
    .imem_rd     (imem_rd),
    .pc          (pc),
    .if_id_instr (if_id_instr),
    .if_id_pc4   (if_id_pc4),
    .if_id_valid (if_id_valid),
    .fetch_fault (fetch_fault)
  );

  assign imem_rd = rom[imem_addr];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Advance one rising edge and settle just after it.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_ifid(input string tag, input logic [31:0] e_pc, input logic [31:0] e_instr,
                            input logic [31:0] e_pc4, input logic e_valid);
    check_eq({tag, ".pc"},    pc,          e_pc);
    check_eq({tag, ".instr"}, if_id_instr, e_instr);
    check_eq({tag, ".pc4"},   if_id_pc4,   e_pc4);
    check_eq({tag, ".valid"}, 32'(if_id_valid), 32'd1 & 32'(e_valid));
  endtask

  initial begin
    for (int i = 0; i < 512; i++) rom[i] = 32'h1000_0000 | 32'(i);
    rom[0] = 32'h11; rom[1] = 32'h22; rom[2] = 32'h33; rom[3] = 32'h44;

    rst = 1'b1; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
    #2;
    step();
    check_ifid("reset", 32'h3000, 32'h0, 32'h0, 1'b0);
    check_eq("reset.fault", 32'(fetch_fault), 32'd0);
    check_eq("reset.addr", 32'(imem_addr), 32'd0);
    rst = 1'b0;

    // Free-running fetch of words 0..1
    step(); check_ifid("run1", 32'h3004, 32'h11, 32'h3004, 1'b1);
    check_eq("run1.addr", 32'(imem_addr), 32'd1);
    step(); check_ifid("run2", 32'h3008, 32'h22, 32'h3008, 1'b1);

    // Two stall cycles at pc=0x3008
    stall = 1'b1;
    step(); check_ifid("stall1", 32'h3008, 32'h22, 32'h3008, 1'b1);
    step(); check_ifid("stall2", 32'h3008, 32'h22, 32'h3008, 1'b1);
    stall = 1'b0;
    step(); check_ifid("run3", 32'h300C, 32'h33, 32'h300C, 1'b1);
    step(); check_ifid("run4", 32'h3010, 32'h44, 32'h3010, 1'b1);

    // Redirect wins over stall
    redirect = 1'b1; redirect_pc = 32'h3040; stall = 1'b1;
    step();
    check_eq("redir.pc", pc, 32'h3040);
    check_eq("redir.valid", 32'(if_id_valid), 32'd0);
    check_eq("redir.instr", if_id_instr, 32'h0);
    redirect = 1'b0; stall = 1'b0;
    step(); check_ifid("redir.next", 32'h3044, 32'h1000_0010, 32'h3044, 1'b1);

    // Misaligned redirect target is accepted, then faults one edge later
    redirect = 1'b1; redirect_pc = 32'h3002;
    step();
    redirect = 1'b0;
    check_eq("mis.pc", pc, 32'h3002);
    check_eq("mis.fault_pre", 32'(fetch_fault), 32'd0);
    step();
    check_eq("mis.fault", 32'(fetch_fault), 32'd1);
    check_eq("mis.valid", 32'(if_id_valid), 32'd0);
    check_eq("mis.pc_hold", pc, 32'h3002);
    for (int i = 0; i < 10; i++) begin
      if (i == 4) begin
        redirect = 1'b1; redirect_pc = 32'h3100;
      end else begin
        redirect = 1'b0;
      end
      step();
      check_eq($sformatf("halt%0d.pc", i), pc, 32'h3002);
      check_eq($sformatf("halt%0d.valid", i), 32'(if_id_valid), 32'd0);
      check_eq($sformatf("halt%0d.fault", i), 32'(fetch_fault), 32'd1);
    end
    redirect = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    check_eq("unhalt.fault", 32'(fetch_fault), 32'd0);
    check_ifid("unhalt", 32'h3000, 32'h0, 32'h0, 1'b0);
    step(); check_ifid("unhalt.run", 32'h3004, 32'h11, 32'h3004, 1'b1);

    // Upper ROM boundary: word 501 is fetched, index 502 faults
    redirect = 1'b1; redirect_pc = 32'h37D0;
    step();
    redirect = 1'b0;
    check_eq("top.pc", pc, 32'h37D0);
    step(); check_ifid("w500", 32'h37D4, 32'h1000_01F4, 32'h37D4, 1'b1);
    step(); check_ifid("w501", 32'h37D8, 32'h1000_01F5, 32'h37D8, 1'b1);
    check_eq("w501.fault", 32'(fetch_fault), 32'd0);
    check_eq("w502.addr", 32'(imem_addr), 32'd502);
    step();
    check_eq("w502.fault", 32'(fetch_fault), 32'd1);
    check_eq("w502.valid", 32'(if_id_valid), 32'd0);
    check_eq("w502.instr", if_id_instr, 32'h0);
    check_eq("w502.pc", pc, 32'h37D8);
    step();
    check_eq("w502.pc_hold", pc, 32'h37D8);

    // Reset mid-stream overrides stall and redirect
    rst = 1'b1; step(); rst = 1'b0;
    step(); step();
    check_ifid("mid.pre", 32'h3008, 32'h22, 32'h3008, 1'b1);
    rst = 1'b1; stall = 1'b1; redirect = 1'b1; redirect_pc = 32'h3100;
    step();
    check_ifid("mid.rst", 32'h3000, 32'h0, 32'h0, 1'b0);
    check_eq("mid.fault", 32'(fetch_fault), 32'd0);
    rst = 1'b0; stall = 1'b0; redirect = 1'b0;
    step(); check_ifid("mid.run", 32'h3004, 32'h11, 32'h3004, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
